// File: rtl/wumpus_move_cmd_if.sv
// Switch inputs and move-command outputs of the Wumpus move command block.
// master: the command block; slave: whatever drives the switches and consumes moves.
interface wumpus_move_cmd_if;
    logic       switchDi;
    logic       switchEs;
    logic       switchCi;
    logic       switchBa;
    logic       switch;
    logic       move_valid;
    logic [1:0] move_dir;
    logic       move_err;
    logic [7:0] move_count;

    modport master (
        input  switchDi,
        input  switchEs,
        input  switchCi,
        input  switchBa,
        input  switch,
        output move_valid,
        output move_dir,
        output move_err,
        output move_count
    );

    modport slave (
        output switchDi,
        output switchEs,
        output switchCi,
        output switchBa,
        output switch,
        input  move_valid,
        input  move_dir,
        input  move_err,
        input  move_count
    );
endinterface

// File: rtl/wumpus_move_cmd.sv
// Debounces four direction switches plus a confirm button and issues one move per press.
// Define WUMPUS_MOVE_COUNT_EN to build the saturating move_count counter.
module wumpus_move_cmd #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic                  clock,
    input  logic                  reset,
    wumpus_move_cmd_if.master     bus
);

    localparam int             CW   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]  CMAX = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0]  ONE  = CW'(1);
    localparam int             NCH  = 5;
    localparam int             CONF = 4;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        HOLD
    } state_e;

    logic [NCH-1:0] raw;
    logic [NCH-1:0] sync1_q;
    logic [NCH-1:0] sync2_q;
    logic [NCH-1:0] deb_q;
    logic [NCH-1:0] deb_d;
    logic [CW-1:0]  cnt_q [NCH];
    logic [CW-1:0]  cnt_d [NCH];
    logic           conf_prev_q;

    state_e         state_q;
    state_e         state_d;
    logic [1:0]     dir_q;
    logic [1:0]     dir_d;
    logic           err_q;
    logic           err_d;
    logic [1:0]     dir_code;
    logic           one_hot;
    logic           rise;

    assign raw = {bus.switch, bus.switchBa, bus.switchCi,
                  bus.switchEs, bus.switchDi};

    // Counter only runs while levels differ; the last differing count flips the level
    always_comb begin
        deb_d = deb_q;
        for (int i = 0; i < NCH; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != deb_q[i]) begin
                if (cnt_q[i] == CMAX) begin
                    deb_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + ONE;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            deb_q       <= '0;
            conf_prev_q <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q     <= raw;
            sync2_q     <= sync1_q;
            deb_q       <= deb_d;
            conf_prev_q <= deb_q[CONF];
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign rise = deb_q[CONF] & ~conf_prev_q;

    always_comb begin
        one_hot  = 1'b1;
        dir_code = 2'b00;
        unique case (deb_q[3:0])
            4'b0001: dir_code = 2'b00;
            4'b0010: dir_code = 2'b01;
            4'b0100: dir_code = 2'b10;
            4'b1000: dir_code = 2'b11;
            default: one_hot  = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        err_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (rise) begin
                    if (one_hot) begin
                        state_d = ISSUE;
                        dir_d   = dir_code;
                    end else begin
                        state_d = HOLD;
                        err_d   = 1'b1;
                    end
                end
            end
            ISSUE: begin
                state_d = HOLD;
            end
            HOLD: begin
                if (!deb_q[CONF]) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= IDLE;
            dir_q   <= 2'b00;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            err_q   <= err_d;
        end
    end

    assign bus.move_valid = (state_q == ISSUE);
    assign bus.move_err   = err_q;
    assign bus.move_dir   = dir_q;

`ifdef WUMPUS_MOVE_COUNT_EN
    logic [7:0] count_q;
    logic [7:0] count_d;

    always_comb begin
        count_d = count_q;
        if (state_q == ISSUE && count_q != 8'hFF) begin
            count_d = count_q + 8'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            count_q <= 8'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign bus.move_count = count_q;
`else
    assign bus.move_count = 8'd0;
`endif

endmodule

// File: tb/tb_wumpus_move_cmd.sv
// Directed and random checks of wumpus_move_cmd against a stream-level reference model.
module tb_wumpus_move_cmd;

    localparam int D = 4;
`ifdef WUMPUS_MOVE_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] in_v = '0;
    int         total = 0;
    int         bad = 0;

    wumpus_move_cmd_if bus ();

    assign bus.switchDi = in_v[0];
    assign bus.switchEs = in_v[1];
    assign bus.switchCi = in_v[2];
    assign bus.switchBa = in_v[3];
    assign bus.switch   = in_v[4];

    wumpus_move_cmd #(.DEBOUNCE_CYCLES(D)) dut (
        .clock (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference: a level flips once the synchronised stream has held the other value D clocks
    logic [4:0] s1, s2, deb;
    int         run [5];
    logic       cprev, armed, mv, me;
    logic [1:0] md;
    int         mc;

    task automatic model_edge(input logic [4:0] r, input logic rs);
        logic nmv, nme;
        if (!rs) begin
            s1 = '0; s2 = '0; deb = '0;
            for (int i = 0; i < 5; i++) run[i] = 1;
            cprev = 0; armed = 1; mv = 0; me = 0; md = 2'b00; mc = 0;
            return;
        end
        if (CNT_EN && mv && mc < 255) mc++;
        nmv = 0; nme = 0;
        if (armed && deb[4] && !cprev) begin
            armed = 0;
            if ($countones(deb[3:0]) == 1) begin
                nmv = 1;
                for (int i = 0; i < 4; i++) if (deb[i]) md = 2'(i);
            end else begin
                nme = 1;
            end
        end else if (!armed && !deb[4]) begin
            armed = 1;
        end
        cprev = deb[4];
        for (int i = 0; i < 5; i++)
            if (s2[i] != deb[i] && run[i] >= D) deb[i] = s2[i];
        for (int i = 0; i < 5; i++)
            run[i] = (s1[i] == s2[i]) ? ((run[i] < 1000) ? run[i] + 1 : run[i]) : 1;
        s2 = s1; s1 = r; mv = nmv; me = nme;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge(in_v, rst_n);
        #1;
        chk("valid", 8'(bus.move_valid), 8'(mv));
        chk("err",   8'(bus.move_err),   8'(me));
        chk("dir",   8'(bus.move_dir),   8'(md));
        chk("count", bus.move_count,     8'(mc));
        chk("excl",  8'(bus.move_valid & bus.move_err), 8'd0);
    endtask

    task automatic run_n(input int n, output int nv, output int ne);
        nv = 0; ne = 0;
        for (int k = 0; k < n; k++) begin
            tick();
            nv += int'(bus.move_valid);
            ne += int'(bus.move_err);
        end
    endtask

    int nv, ne, lat;

    initial begin
        rst_n = 1'b0;
        in_v  = '0;
        tick();
        tick();
        chk("rst_valid", 8'(bus.move_valid), 8'd0);
        chk("rst_count", bus.move_count, 8'd0);
        rst_n = 1'b1;

        // clean press with "up" held: fixed latency, single pulse
        in_v = 5'b00100;
        run_n(12, nv, ne);
        in_v[4] = 1'b1;
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (bus.move_valid && lat < 0) lat = k;
        end
        chk("latency", 8'(lat), 8'd7);
        chk("up_dir", 8'(bus.move_dir), 8'd2);
        run_n(20, nv, ne);
        chk("no_second", 8'(nv), 8'd0);
        in_v[4] = 1'b0;
        run_n(12, nv, ne);

        // bouncy confirm with "right"
        in_v = 5'b00001;
        run_n(8, nv, ne);
        for (int k = 0; k < 3; k++) begin
            in_v[4] = ~in_v[4];
            tick();
        end
        in_v[4] = 1'b1;
        run_n(30, nv, ne);
        chk("bounce_one", 8'(nv), 8'd1);
        chk("right_dir", 8'(bus.move_dir), 8'd0);
        in_v[4] = 1'b0;
        run_n(12, nv, ne);

        // short bounces only: nothing
        for (int k = 0; k < 12; k++) begin
            in_v[4] = (k % 3 != 2);
            tick();
        end
        in_v[4] = 1'b0;
        run_n(12, nv, ne);
        chk("short_none", 8'(nv), 8'd0);

        // two directions and no direction: error pulses
        in_v = 5'b01001;
        run_n(8, nv, ne);
        in_v[4] = 1'b1;
        run_n(20, nv, ne);
        chk("two_err", 8'(ne), 8'd1);
        chk("two_valid", 8'(nv), 8'd0);
        chk("two_dir", 8'(bus.move_dir), 8'd0);
        in_v = 5'b00000;
        run_n(12, nv, ne);
        in_v[4] = 1'b1;
        run_n(20, nv, ne);
        chk("none_err", 8'(ne), 8'd1);
        in_v[4] = 1'b0;
        run_n(12, nv, ne);

        // left: press, release, press; then change direction while held
        in_v = 5'b00010;
        run_n(8, nv, ne);
        in_v[4] = 1'b1;
        run_n(10, nv, ne);
        lat = nv;
        in_v[4] = 1'b0;
        run_n(10, nv, ne);
        in_v[4] = 1'b1;
        run_n(10, nv, ne);
        chk("left_two", 8'(lat + nv), 8'd2);
        chk("left_dir", 8'(bus.move_dir), 8'd1);
        in_v[1] = 1'b0;
        in_v[3] = 1'b1;
        run_n(15, nv, ne);
        chk("chg_none", 8'(nv + ne), 8'd0);
        in_v[4] = 1'b0;
        run_n(12, nv, ne);

        // reset during confirm debounce
        in_v = 5'b00100;
        run_n(8, nv, ne);
        in_v[4] = 1'b1;
        run_n(4, nv, ne);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("rstm_valid", 8'(bus.move_valid), 8'd0);
        chk("rstm_err", 8'(bus.move_err), 8'd0);
        chk("rstm_dir", 8'(bus.move_dir), 8'd0);
        chk("rstm_count", bus.move_count, 8'd0);
        run_n(5, nv, ne);
        chk("rstm_none", 8'(nv), 8'd0);
        run_n(20, nv, ne);
        chk("rstm_repress", 8'(nv), 8'd1);
        in_v[4] = 1'b0;
        run_n(12, nv, ne);

        // random phases, occasional resets
        for (int p = 0; p < 300; p++) begin
            in_v = 5'($urandom);
            if ($urandom_range(0, 40) == 0) rst_n = 1'b0;
            for (int k = 0; k < int'($urandom_range(1, 14)); k++) begin
                tick();
                rst_n = 1'b1;
                if ($urandom_range(0, 7) == 0) in_v[4] = ~in_v[4];
            end
        end
        rst_n = 1'b1;
        in_v = '0;
        run_n(12, nv, ne);

        // counter saturation
        in_v = 5'b01000;
        run_n(8, nv, ne);
        for (int p = 0; p < 300; p++) begin
            in_v[4] = 1'b1;
            run_n(8, nv, ne);
            in_v[4] = 1'b0;
            run_n(8, nv, ne);
        end
        run_n(4, nv, ne);
        chk("count_sat", bus.move_count, CNT_EN ? 8'd255 : 8'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
